// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths and types for the memory port arbiter
package mem_port_arbiter_pkg;
  localparam int DATA_WIDTH  = 64;
  localparam int FETCH_WIDTH = 64;
  localparam int SIZE_W      = $clog2(FETCH_WIDTH / 8);

  typedef enum logic {IMEM = 1'b0, DMEM = 1'b1} e_mem_port;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} e_arb_state;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  addr;
    logic                   we;
    logic [SIZE_W-1:0]      size;
    logic [FETCH_WIDTH-1:0] data;
  } mem_request;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - core-port and memory-bus signal bundle for the arbiter
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic                   imem_rd_en_i;
  logic [DATA_WIDTH-1:0]  imem_addr_i;
  logic                   imem_busy_o;
  logic                   imem_rdy_o;
  logic [FETCH_WIDTH-1:0] imem_rd_data_o;

  logic                   dmem_rd_en_i;
  logic                   dmem_wr_en_i;
  logic [DATA_WIDTH-1:0]  dmem_addr_i;
  logic [SIZE_W-1:0]      dmem_wr_size_i;
  logic [FETCH_WIDTH-1:0] dmem_wr_data_i;
  logic                   dmem_busy_o;
  logic                   dmem_rdy_o;
  logic [FETCH_WIDTH-1:0] dmem_rd_data_o;

  logic                   mem_req_o;
  logic                   mem_we_o;
  logic [DATA_WIDTH-1:0]  mem_addr_o;
  logic [SIZE_W-1:0]      mem_wr_size_o;
  logic [FETCH_WIDTH-1:0] mem_wr_data_o;
  logic                   mem_gnt_i;
  logic                   mem_rvalid_i;
  logic [FETCH_WIDTH-1:0] mem_rd_data_i;

  modport slave (
    input  imem_rd_en_i, imem_addr_i,
    output imem_busy_o, imem_rdy_o, imem_rd_data_o,
    input  dmem_rd_en_i, dmem_wr_en_i, dmem_addr_i, dmem_wr_size_i, dmem_wr_data_i,
    output dmem_busy_o, dmem_rdy_o, dmem_rd_data_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wr_size_o, mem_wr_data_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rd_data_i
  );

  modport master (
    output imem_rd_en_i, imem_addr_i,
    input  imem_busy_o, imem_rdy_o, imem_rd_data_o,
    output dmem_rd_en_i, dmem_wr_en_i, dmem_addr_i, dmem_wr_size_i, dmem_wr_data_i,
    input  dmem_busy_o, dmem_rdy_o, dmem_rd_data_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wr_size_o, mem_wr_data_o,
    output mem_gnt_i, mem_rvalid_i, mem_rd_data_i
  );
endinterface

// File: rtl/mem_port_arbiter_req_buffer.sv
// rtl/mem_port_arbiter_req_buffer.sv - one-entry request buffer with busy flag
// next_valid/next_req look through a capture happening this cycle so the arbiter can grant it at once.
module mem_port_arbiter_req_buffer
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  mem_request incoming,
  input  logic       clear,
  output logic       busy,
  output logic       next_valid,
  output mem_request next_req
);
  mem_request held;
  logic       capture;

  assign capture = en && !busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      held <= '0;
    end else if (capture) begin
      busy <= 1'b1;
      held <= incoming;
    end else if (clear) begin
      busy <= 1'b0;
    end
  end

  assign next_valid = busy || capture;
  assign next_req   = capture ? incoming : held;
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - merges imem and dmem ports onto one memory bus
// One transaction in flight at a time; ties are broken round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  mem_request imem_incoming, dmem_incoming, imem_next, dmem_next, pick_req;
  logic       imem_next_valid, dmem_next_valid, imem_clear, dmem_clear;
  e_arb_state state;
  e_mem_port  grant, last_grant, pick;

  assign imem_incoming = '{addr: bus.imem_addr_i, we: 1'b0,
                           size: {SIZE_W{1'b0}}, data: {FETCH_WIDTH{1'b0}}};
  assign dmem_incoming = '{addr: bus.dmem_addr_i, we: bus.dmem_wr_en_i,
                           size: bus.dmem_wr_size_i, data: bus.dmem_wr_data_i};

  mem_port_arbiter_req_buffer u_imem_buf (
    .clk(clk), .rst(rst), .en(bus.imem_rd_en_i), .incoming(imem_incoming),
    .clear(imem_clear), .busy(bus.imem_busy_o),
    .next_valid(imem_next_valid), .next_req(imem_next)
  );

  mem_port_arbiter_req_buffer u_dmem_buf (
    .clk(clk), .rst(rst), .en(bus.dmem_rd_en_i || bus.dmem_wr_en_i),
    .incoming(dmem_incoming), .clear(dmem_clear), .busy(bus.dmem_busy_o),
    .next_valid(dmem_next_valid), .next_req(dmem_next)
  );

  assign imem_clear = (state == RESP) && (grant == IMEM);
  assign dmem_clear = (state == RESP) && (grant == DMEM);

  always_comb begin
    pick = IMEM;
    if (imem_next_valid && dmem_next_valid) begin
      pick = (last_grant == IMEM) ? DMEM : IMEM;
    end else if (dmem_next_valid) begin
      pick = DMEM;
    end
    pick_req = (pick == DMEM) ? dmem_next : imem_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      grant              <= IMEM;
      last_grant         <= IMEM;
      bus.mem_req_o      <= 1'b0;
      bus.mem_we_o       <= 1'b0;
      bus.mem_addr_o     <= '0;
      bus.mem_wr_size_o  <= '0;
      bus.mem_wr_data_o  <= '0;
      bus.imem_rdy_o     <= 1'b0;
      bus.dmem_rdy_o     <= 1'b0;
      bus.imem_rd_data_o <= '0;
      bus.dmem_rd_data_o <= '0;
    end else begin
      bus.imem_rdy_o <= 1'b0;
      bus.dmem_rdy_o <= 1'b0;
      case (state)
        IDLE: begin
          if (imem_next_valid || dmem_next_valid) begin
            grant <= pick;
            if (imem_next_valid && dmem_next_valid) last_grant <= pick;
            bus.mem_req_o     <= 1'b1;
            bus.mem_we_o      <= pick_req.we;
            bus.mem_addr_o    <= pick_req.addr;
            bus.mem_wr_size_o <= pick_req.size;
            bus.mem_wr_data_o <= pick_req.data;
            state             <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_gnt_i) begin
            bus.mem_req_o <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid_i) begin
            if (grant == IMEM) begin
              bus.imem_rdy_o     <= 1'b1;
              bus.imem_rd_data_o <= bus.mem_rd_data_i;
            end else begin
              bus.dmem_rdy_o <= 1'b1;
              if (!bus.mem_we_o) bus.dmem_rd_data_o <= bus.mem_rd_data_i;
            end
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [63:0] exp_dmem;

  mem_port_arbiter_if arb_bus ();

  mem_port_arbiter dut (.clk(clk), .rst(rst), .bus(arb_bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    int          stall;
    logic [63:0] rdata;
    logic        exp_we;
    logic [2:0]  exp_size;
    logic [63:0] exp_wdata;
    logic [63:0] exp_imem;
    logic [63:0] exp_dmem;
  } vec_t;

  vec_t vecs[7];
  vec_t v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_of(input logic p);
    return p ? arb_bus.dmem_rdy_o : arb_bus.imem_rdy_o;
  endfunction

  function automatic logic busy_of(input logic p);
    return p ? arb_bus.dmem_busy_o : arb_bus.imem_busy_o;
  endfunction

  function automatic logic [63:0] data_of(input logic p);
    return p ? arb_bus.dmem_rd_data_o : arb_bus.imem_rd_data_o;
  endfunction

  task automatic clear_inputs;
    arb_bus.imem_rd_en_i   = 1'b0;
    arb_bus.imem_addr_i    = '0;
    arb_bus.dmem_rd_en_i   = 1'b0;
    arb_bus.dmem_wr_en_i   = 1'b0;
    arb_bus.dmem_addr_i    = '0;
    arb_bus.dmem_wr_size_i = '0;
    arb_bus.dmem_wr_data_i = '0;
    arb_bus.mem_gnt_i      = 1'b0;
    arb_bus.mem_rvalid_i   = 1'b0;
    arb_bus.mem_rd_data_i  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_imem_busy"}, arb_bus.imem_busy_o, 0);
    chk({tag, "_imem_rdy"}, arb_bus.imem_rdy_o, 0);
    chk({tag, "_imem_rd_data"}, arb_bus.imem_rd_data_o, 0);
    chk({tag, "_dmem_busy"}, arb_bus.dmem_busy_o, 0);
    chk({tag, "_dmem_rdy"}, arb_bus.dmem_rdy_o, 0);
    chk({tag, "_dmem_rd_data"}, arb_bus.dmem_rd_data_o, 0);
    chk({tag, "_mem_req"}, arb_bus.mem_req_o, 0);
    chk({tag, "_mem_we"}, arb_bus.mem_we_o, 0);
    chk({tag, "_mem_addr"}, arb_bus.mem_addr_o, 0);
    chk({tag, "_mem_size"}, 64'(arb_bus.mem_wr_size_o), 0);
    chk({tag, "_mem_wdata"}, arb_bus.mem_wr_data_o, 0);
  endtask

  // Entered in a REQ cycle; returns in the RESP cycle after checking the response.
  task automatic serve(input string tag, input logic p, input logic [63:0] addr,
                       input logic [63:0] rdata);
    chk({tag, "_req"}, arb_bus.mem_req_o, 1);
    chk({tag, "_addr"}, arb_bus.mem_addr_o, addr);
    arb_bus.mem_gnt_i = 1'b1;
    tick;
    arb_bus.mem_gnt_i = 1'b0;
    chk({tag, "_wait_req"}, arb_bus.mem_req_o, 0);
    arb_bus.mem_rvalid_i  = 1'b1;
    arb_bus.mem_rd_data_i = rdata;
    tick;
    arb_bus.mem_rvalid_i  = 1'b0;
    arb_bus.mem_rd_data_i = 64'h0BAD_0BAD_0BAD_0BAD;
    chk({tag, "_rdy"}, rdy_of(p), 1);
    chk({tag, "_other_rdy"}, rdy_of(!p), 0);
    chk({tag, "_rd_data"}, data_of(p), rdata);
  endtask

  logic        tie_first[3];
  logic [63:0] ia, da, fa, sa;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 64'h1000, 3'd0, 64'h0, 0, 64'hDEADBEEF_00000013,
                1'b0, 3'd0, 64'h0, 64'hDEADBEEF_00000013, 64'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 64'h2008, 3'd3, 64'h55, 4, 64'hFFFF0000_FFFF0000,
                1'b1, 3'd3, 64'h55, 64'hDEADBEEF_00000013, 64'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 64'h3000, 3'd0, 64'h0, 1, 64'h01234567_89ABCDEF,
                1'b0, 3'd0, 64'h0, 64'hDEADBEEF_00000013, 64'h01234567_89ABCDEF};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 64'h3010, 3'd2, 64'hAA, 0, 64'h9999,
                1'b1, 3'd2, 64'hAA, 64'hDEADBEEF_00000013, 64'h01234567_89ABCDEF};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 64'h1004, 3'd0, 64'h0, 2, 64'hCAFEF00D_00000001,
                1'b0, 3'd0, 64'h0, 64'hCAFEF00D_00000001, 64'h01234567_89ABCDEF};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 64'h0, 3'd0, 64'h0, 0, 64'hFFFFFFFF_FFFFFFFF,
                1'b0, 3'd0, 64'h0, 64'hCAFEF00D_00000001, 64'hFFFFFFFF_FFFFFFFF};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFF8, 3'd7, 64'hFFFFFFFF_FFFFFFFF, 1,
                64'h0, 1'b1, 3'd7, 64'hFFFFFFFF_FFFFFFFF, 64'hCAFEF00D_00000001,
                64'hFFFFFFFF_FFFFFFFF};
    tie_first[0] = 1'b1;
    tie_first[1] = 1'b0;
    tie_first[2] = 1'b1;

    clear_inputs();
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      if (v.port == 1'b0) begin
        arb_bus.imem_rd_en_i = v.rd;
        arb_bus.imem_addr_i  = v.addr;
      end else begin
        arb_bus.dmem_rd_en_i   = v.rd;
        arb_bus.dmem_wr_en_i   = v.wr;
        arb_bus.dmem_addr_i    = v.addr;
        arb_bus.dmem_wr_size_i = v.size;
        arb_bus.dmem_wr_data_i = v.wdata;
      end
      tick;
      arb_bus.imem_rd_en_i   = 1'b0;
      arb_bus.dmem_rd_en_i   = 1'b0;
      arb_bus.dmem_wr_en_i   = 1'b0;
      arb_bus.imem_addr_i    = 64'hA5A5_A5A5_A5A5_A5A5;
      arb_bus.dmem_addr_i    = 64'hA5A5_A5A5_A5A5_A5A5;
      arb_bus.dmem_wr_size_i = 3'd1;
      arb_bus.dmem_wr_data_i = 64'hA5A5_A5A5_A5A5_A5A5;
      chk($sformatf("v%0d_busy", i), busy_of(v.port), 1);
      chk($sformatf("v%0d_req", i), arb_bus.mem_req_o, 1);
      chk($sformatf("v%0d_we", i), arb_bus.mem_we_o, v.exp_we);
      chk($sformatf("v%0d_addr", i), arb_bus.mem_addr_o, v.addr);
      chk($sformatf("v%0d_size", i), 64'(arb_bus.mem_wr_size_o), 64'(v.exp_size));
      chk($sformatf("v%0d_wdata", i), arb_bus.mem_wr_data_o, v.exp_wdata);
      for (int s = 0; s < v.stall; s++) begin
        tick;
        chk($sformatf("v%0d_hold%0d_req", i, s), arb_bus.mem_req_o, 1);
        chk($sformatf("v%0d_hold%0d_fields", i, s),
            arb_bus.mem_addr_o ^ arb_bus.mem_wr_data_o, v.addr ^ v.exp_wdata);
        chk($sformatf("v%0d_hold%0d_we", i, s), arb_bus.mem_we_o, v.exp_we);
      end
      arb_bus.mem_gnt_i = 1'b1;
      tick;
      arb_bus.mem_gnt_i = 1'b0;
      chk($sformatf("v%0d_wait_req", i), arb_bus.mem_req_o, 0);
      chk($sformatf("v%0d_wait_rdy", i), rdy_of(v.port), 0);
      arb_bus.mem_rvalid_i  = 1'b1;
      arb_bus.mem_rd_data_i = v.rdata;
      tick;
      arb_bus.mem_rvalid_i  = 1'b0;
      arb_bus.mem_rd_data_i = 64'h0BAD_0BAD_0BAD_0BAD;
      chk($sformatf("v%0d_rdy", i), rdy_of(v.port), 1);
      chk($sformatf("v%0d_other_rdy", i), rdy_of(!v.port), 0);
      chk($sformatf("v%0d_resp_busy", i), busy_of(v.port), 1);
      chk($sformatf("v%0d_imem_data", i), arb_bus.imem_rd_data_o, v.exp_imem);
      chk($sformatf("v%0d_dmem_data", i), arb_bus.dmem_rd_data_o, v.exp_dmem);
      tick;
      chk($sformatf("v%0d_rdy_pulse", i), rdy_of(v.port), 0);
      chk($sformatf("v%0d_idle_busy", i), busy_of(v.port), 0);
    end

    // Simultaneous requests: DMEM, IMEM, DMEM win the successive ties.
    for (int k = 0; k < 3; k++) begin
      ia = 64'h1100 + 64'(k) * 64'h100;
      da = 64'h2200 + 64'(k) * 64'h100;
      arb_bus.imem_rd_en_i = 1'b1;
      arb_bus.imem_addr_i  = ia;
      arb_bus.dmem_rd_en_i = 1'b1;
      arb_bus.dmem_addr_i  = da;
      tick;
      arb_bus.imem_rd_en_i = 1'b0;
      arb_bus.dmem_rd_en_i = 1'b0;
      chk($sformatf("tie%0d_both_busy", k), {arb_bus.imem_busy_o, arb_bus.dmem_busy_o}, 2'b11);
      fa = tie_first[k] ? da : ia;
      sa = tie_first[k] ? ia : da;
      serve($sformatf("tie%0d_first", k), tie_first[k], fa, 64'hF000 + 64'(k));
      tick;
      chk($sformatf("tie%0d_bubble_req", k), arb_bus.mem_req_o, 0);
      chk($sformatf("tie%0d_second_busy", k), busy_of(!tie_first[k]), 1);
      tick;
      serve($sformatf("tie%0d_second", k), !tie_first[k], sa, 64'h5000 + 64'(k));
      tick;
      chk($sformatf("tie%0d_idle_busy", k), {arb_bus.imem_busy_o, arb_bus.dmem_busy_o}, 2'b00);
    end
    exp_dmem = 64'hF002;

    // Re-issue while busy is dropped; a request after rdy is accepted.
    arb_bus.imem_rd_en_i = 1'b1;
    arb_bus.imem_addr_i  = 64'h1000;
    tick;
    arb_bus.imem_rd_en_i = 1'b0;
    chk("reissue_addr", arb_bus.mem_addr_o, 64'h1000);
    arb_bus.mem_gnt_i = 1'b1;
    tick;
    arb_bus.mem_gnt_i     = 1'b0;
    arb_bus.imem_rd_en_i  = 1'b1;
    arb_bus.imem_addr_i   = 64'h1004;
    arb_bus.mem_rvalid_i  = 1'b1;
    arb_bus.mem_rd_data_i = 64'h11;
    tick;
    arb_bus.mem_rvalid_i = 1'b0;
    chk("reissue_rdy", arb_bus.imem_rdy_o, 1);
    chk("reissue_data", arb_bus.imem_rd_data_o, 64'h11);
    arb_bus.imem_addr_i = 64'h1006;
    tick;
    chk("reissue_idle_busy", arb_bus.imem_busy_o, 0);
    chk("reissue_idle_req", arb_bus.mem_req_o, 0);
    arb_bus.imem_addr_i = 64'h1008;
    tick;
    arb_bus.imem_rd_en_i = 1'b0;
    serve("after_rdy", 1'b0, 64'h1008, 64'h22);
    tick;

    // Stray rvalid in IDLE and in REQ.
    arb_bus.mem_rvalid_i  = 1'b1;
    arb_bus.mem_rd_data_i = 64'hBAD;
    tick;
    arb_bus.mem_rvalid_i = 1'b0;
    chk("stray_idle_rdy", {arb_bus.imem_rdy_o, arb_bus.dmem_rdy_o}, 2'b00);
    chk("stray_idle_imem", arb_bus.imem_rd_data_o, 64'h22);
    chk("stray_idle_dmem", arb_bus.dmem_rd_data_o, exp_dmem);
    arb_bus.imem_rd_en_i = 1'b1;
    arb_bus.imem_addr_i  = 64'h1010;
    tick;
    arb_bus.imem_rd_en_i  = 1'b0;
    arb_bus.mem_rvalid_i  = 1'b1;
    arb_bus.mem_rd_data_i = 64'hBAD2;
    tick;
    arb_bus.mem_rvalid_i = 1'b0;
    chk("stray_req_rdy", arb_bus.imem_rdy_o, 0);
    chk("stray_req_data", arb_bus.imem_rd_data_o, 64'h22);
    serve("stray_req_serve", 1'b0, 64'h1010, 64'h33);
    tick;

    // Reset in WAIT abandons the transaction.
    arb_bus.dmem_wr_en_i   = 1'b1;
    arb_bus.dmem_addr_i    = 64'h2040;
    arb_bus.dmem_wr_size_i = 3'd3;
    arb_bus.dmem_wr_data_i = 64'h99;
    tick;
    arb_bus.dmem_wr_en_i = 1'b0;
    arb_bus.mem_gnt_i    = 1'b1;
    tick;
    arb_bus.mem_gnt_i = 1'b0;
    chk("midrst_pre_busy", arb_bus.dmem_busy_o, 1);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    arb_bus.imem_rd_en_i = 1'b1;
    arb_bus.imem_addr_i  = 64'h1000;
    tick;
    arb_bus.imem_rd_en_i = 1'b0;
    serve("post_rst", 1'b0, 64'h1000, 64'h42);
    tick;
    chk("post_rst_busy", arb_bus.imem_busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly downstream of the core's two memory ports (imem fetch, dmem load/store) and merges them onto one unified memory bus.
- Each core port gets a one-entry request buffer and a busy/rdy handshake.
- Transactions go to memory one at a time, with round-robin arbitration on conflict.
- Returns read data to the requesting port and acknowledges writes.

Parameters:
DATA_WIDTH, 64, address width of both core ports and the memory bus
FETCH_WIDTH, 64, data word width of all data buses
SIZE_W, $clog2(FETCH_WIDTH/8), width of the write-size field

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
imem_rd_en_i  input  1  fetch read request
imem_addr_i  input  DATA_WIDTH  fetch address
imem_busy_o  output  1  fetch port holds an unserviced request
imem_rdy_o  output  1  one-cycle pulse: imem_rd_data_o valid
imem_rd_data_o  output  FETCH_WIDTH  fetch data
dmem_rd_en_i  input  1  load request
dmem_wr_en_i  input  1  store request
dmem_addr_i  input  DATA_WIDTH  load/store address
dmem_wr_size_i  input  SIZE_W  store size code, passed through unchanged
dmem_wr_data_i  input  FETCH_WIDTH  store data
dmem_busy_o  output  1  data port holds an unserviced request
dmem_rdy_o  output  1  one-cycle pulse: load data valid or store done
dmem_rd_data_o  output  FETCH_WIDTH  load data
mem_req_o  output  1  bus request
mem_we_o  output  1  1 = write, 0 = read
mem_addr_o  output  DATA_WIDTH  bus address
mem_wr_size_o  output  SIZE_W  bus write size
mem_wr_data_o  output  FETCH_WIDTH  bus write data
mem_gnt_i  input  1  memory accepted the request this cycle
mem_rvalid_i  input  1  response valid (read data or write ack)
mem_rd_data_i  input  FETCH_WIDTH  response data

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; both pending buffers are cleared.
  - Every output is 0.
  - last_grant is set to IMEM, so the first tie goes to DMEM.
- Capture:
  - A port's request is latched into its buffer when en is high and busy_o is low.
  - The buffer holds addr, we, size and data.
  - busy_o = buffer valid; it rises the cycle after capture.
  - en while busy_o is high is ignored and not queued.
  - dmem_rd_en_i and dmem_wr_en_i both high: captured as a write.
- FSM states IDLE, REQ, WAIT, RESP:
  - IDLE: no buffer valid -> stay in IDLE.
  - IDLE: exactly one buffer valid -> grant it, go to REQ.
  - IDLE: both valid -> grant the port that is not last_grant, update last_grant, go to REQ.
  - REQ: mem_req_o = 1; bus fields are driven from the granted buffer and held stable until mem_gnt_i. gnt -> WAIT.
  - WAIT: mem_req_o = 0. mem_rvalid_i -> latch mem_rd_data_i into a response register, go to RESP.
  - RESP: pulse the granted port's rdy_o for exactly one cycle. On read, that port's rd_data_o = latched data. Clear that buffer at the end of the cycle, go to IDLE.
- rd_data_o holds its value until the next read response for that port. Writes never modify dmem_rd_data_o.
- busy_o stays high during the RESP cycle and is low from the following cycle. An en in the RESP cycle is ignored.
- mem_rvalid_i outside WAIT is ignored. mem_gnt_i outside REQ is ignored. The memory must not return rvalid in the same cycle as gnt.
- Minimum latency, en to rdy: 3 cycles.
  - cycle 0: en
  - cycle 1: REQ, gnt
  - cycle 2: WAIT, rvalid
  - cycle 3: rdy
- The RESP -> IDLE bubble costs 1 extra cycle per back-to-back transaction.
- Only one bus transaction is outstanding at any time.
- Non-granted port's buffer keeps capturing: it may fill while the other port's transaction is in flight.
- Reset mid-transaction abandons the bus transaction. Memory must also be reset by the same rst.

Decomposition:
- Shared package gets:
  - enum e_mem_port {IMEM, DMEM}
  - enum e_arb_state {IDLE, REQ, WAIT, RESP}
  - struct mem_request {addr, we, size, data}, parameterised by package constants.
- Sub-module req_buffer: one-entry capture/hold/clear buffer with busy_o. Instantiated twice; the imem instance has we tied 0.

Test Plan:
1. Single fetch: imem_rd_en_i=1 at addr 0x1000, gnt in cycle 1, rvalid=0xDEADBEEF_00000013 in cycle 2 -> imem_rdy_o pulses in cycle 3 with that data; imem_busy_o high for cycles 1-3.
2. Store: dmem_wr_en_i=1, addr 0x2008, size 3, data 0x55 -> mem_we_o=1 with those fields held through 4 cycles of gnt stall; dmem_rdy_o pulses once; dmem_rd_data_o unchanged.
3. Simultaneous imem and dmem read after reset -> DMEM served first, then IMEM. Repeat with both pending -> IMEM first; grants alternate.
4. Re-issue while busy: a second imem_rd_en_i during WAIT with addr 0x1004 -> ignored, only one bus request seen; a request in the cycle after rdy is accepted.
5. rvalid arriving in REQ state or IDLE -> no rdy pulse, no data change.
6. rst low during WAIT -> all outputs 0 immediately; after release, a fresh fetch completes in 3 cycles.
